// File: rtl/sm3_cf_arbiter.sv
// Round-robin arbiter sharing one SM3 CF compression core among NREQ requesters.
// Optional macro SM3_ARB_LOCK_EN adds a lock input that keeps multi-block messages contiguous.
module sm3_cf_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*256-1:0]   req_iv,
  input  logic [NREQ*512-1:0]   req_blk,
`ifdef SM3_ARB_LOCK_EN
  input  logic [NREQ-1:0]       lock,
`endif
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [255:0]          result,
  output logic                  busy,
  output logic                  cf_start,
  output logic [255:0]          cf_iv,
  output logic [511:0]          cf_blk,
  input  logic [255:0]          cf_hash,
  input  logic                  cf_end
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [NREQ-1:0] gnt_reg, gnt_next;
  logic [NREQ-1:0] done_reg, done_next;
  logic [255:0]    result_reg, result_next;
  logic            cf_start_reg, cf_start_next;
  logic [255:0]    cf_iv_reg, cf_iv_next;
  logic [511:0]    cf_blk_reg, cf_blk_next;
  logic [IW-1:0]   last_reg, last_next;
  logic [IW-1:0]   win_reg, win_next;
  logic [IW-1:0]   arb_idx;

`ifdef SM3_ARB_LOCK_EN
  logic [4:0]      lock_cnt_reg, lock_cnt_next;
`endif

  logic [255:0]    iv_slice  [NREQ];
  logic [511:0]    blk_slice [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign iv_slice[gi]  = req_iv[256*gi +: 256];
      assign blk_slice[gi] = req_blk[512*gi +: 512];
    end
  endgenerate

  function automatic logic [IW-1:0] rr_pos(input logic [IW-1:0] base, input int k);
    int p;
    p = int'(base) + k;
    if (p >= NREQ) p = p - NREQ;
    return IW'(p);
  endfunction

  // Scan from farthest to nearest so the closest set bit after last wins.
  always_comb begin
    arb_idx = last_reg;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[rr_pos(last_reg, k)]) arb_idx = rr_pos(last_reg, k);
    end
  end

  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    done_next     = '0;
    result_next   = result_reg;
    cf_start_next = cf_start_reg;
    cf_iv_next    = cf_iv_reg;
    cf_blk_next   = cf_blk_reg;
    last_next     = last_reg;
    win_next      = win_reg;
`ifdef SM3_ARB_LOCK_EN
    lock_cnt_next = lock_cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (|req) begin
          state_next  = LOAD;
          win_next    = arb_idx;
          gnt_next    = NREQ'(1) << arb_idx;
          cf_iv_next  = iv_slice[arb_idx];
          cf_blk_next = blk_slice[arb_idx];
`ifdef SM3_ARB_LOCK_EN
          lock_cnt_next = '0;
`endif
        end
      end
      LOAD: begin
        state_next    = RUN;
        cf_start_next = 1'b1;
      end
      RUN: begin
        if (cf_end) begin
          state_next    = DONE;
          result_next   = cf_hash;
          cf_start_next = 1'b0;
          done_next     = gnt_reg;
        end
      end
      DONE: begin
        state_next = IDLE;
        last_next  = win_reg;
        gnt_next   = '0;
`ifdef SM3_ARB_LOCK_EN
        // Locked re-grant bypasses arbitration for the next block of the same message.
        if (lock[win_reg] && req[win_reg] && (lock_cnt_reg < 5'd16)) begin
          state_next    = LOAD;
          gnt_next      = gnt_reg;
          cf_iv_next    = iv_slice[win_reg];
          cf_blk_next   = blk_slice[win_reg];
          lock_cnt_next = lock_cnt_reg + 5'd1;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      gnt_reg      <= '0;
      done_reg     <= '0;
      result_reg   <= '0;
      cf_start_reg <= 1'b0;
      cf_iv_reg    <= '0;
      cf_blk_reg   <= '0;
      last_reg     <= IW'(NREQ - 1);
      win_reg      <= '0;
`ifdef SM3_ARB_LOCK_EN
      lock_cnt_reg <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      done_reg     <= done_next;
      result_reg   <= result_next;
      cf_start_reg <= cf_start_next;
      cf_iv_reg    <= cf_iv_next;
      cf_blk_reg   <= cf_blk_next;
      last_reg     <= last_next;
      win_reg      <= win_next;
`ifdef SM3_ARB_LOCK_EN
      lock_cnt_reg <= lock_cnt_next;
`endif
    end
  end

  assign gnt      = gnt_reg;
  assign done     = done_reg;
  assign result   = result_reg;
  assign busy     = (state_reg != IDLE);
  assign cf_start = cf_start_reg;
  assign cf_iv    = cf_iv_reg;
  assign cf_blk   = cf_blk_reg;

endmodule

// File: tb/tb_sm3_cf_arbiter.sv
// Directed bench for sm3_cf_arbiter with a 10-cycle CF core stub.
// Define SM3_ARB_LOCK_EN to also exercise the lock path.
module tb_sm3_cf_arbiter;

  localparam int NREQ = 4;
  localparam logic [255:0] SM3_IV =
    256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
  localparam logic [255:0] ABC_HASH =
    256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
  localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h0}}, 32'h00000018};

  logic                clk;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [NREQ*256-1:0] req_iv;
  logic [NREQ*512-1:0] req_blk;
  logic [NREQ-1:0]     gnt, done;
  logic [255:0]        result;
  logic                busy, cf_start, cf_end;
  logic [255:0]        cf_iv, cf_hash;
  logic [511:0]        cf_blk;
  logic                spur;
  logic [3:0]          stub_cnt;
`ifdef SM3_ARB_LOCK_EN
  logic [NREQ-1:0]     lock;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  sm3_cf_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .reset(reset), .req(req), .req_iv(req_iv), .req_blk(req_blk),
`ifdef SM3_ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt), .done(done), .result(result), .busy(busy), .cf_start(cf_start),
    .cf_iv(cf_iv), .cf_blk(cf_blk), .cf_hash(cf_hash), .cf_end(cf_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Core stub: cf_end on the 10th cycle of cf_start; hash is the real SM3("abc") for that input.
  always @(posedge clk) begin
    if (!cf_start) stub_cnt <= 4'd0;
    else           stub_cnt <= stub_cnt + 4'd1;
  end
  assign cf_end  = (cf_start && stub_cnt == 4'd9) || spur;
  assign cf_hash = (cf_iv === SM3_IV && cf_blk === ABC_BLK) ? ABC_HASH : (cf_iv ^ cf_blk[511:256]);

  // Pattern operands: iv_i = {64{i+1}}, blk_i upper half = {64{A}}, so hash_i = (i+1) ^ A.
  function automatic logic [255:0] exp_hash(input int i);
    case (i)
      0:       return {64{4'hB}};
      1:       return {64{4'h8}};
      2:       return {64{4'h9}};
      default: return {64{4'hE}};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, output logic [NREQ-1:0] d, output int at);
    int n;
    n = 0;
    while (done === '0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    assert (done !== '0) else begin
      miscompares++;
      $error("FAIL %s_timeout: observed done=%b expected a pulse within 60 cycles", tag, done);
    end
    d  = done;
    at = cyc;
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (!cf_start && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    logic [NREQ-1:0] d;
    logic [NREQ-1:0] e;
    int at, prev;
    logic saw;

    reset = 1'b0;
    req   = '0;
    spur  = 1'b0;
`ifdef SM3_ARB_LOCK_EN
    lock  = '0;
`endif
    for (int i = 0; i < NREQ; i++) begin
      req_iv[256*i +: 256]  = {64{4'(i + 1)}};
      req_blk[512*i +: 512] = {{64{4'hA}}, {64{4'(i)}}};
    end
    req_iv[255:0]  = SM3_IV;
    req_blk[511:0] = ABC_BLK;
    repeat (2) @(negedge clk);

    chk("rst_gnt", 256'(gnt), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_result", result, 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_cf_start", 256'(cf_start), 256'(0));
    chk("rst_cf_iv", cf_iv, 256'(0));
    chk("rst_cf_blk", 256'(cf_blk), 256'(0));
    reset = 1'b1;
    @(negedge clk);

    // SM3 "abc" through requester 0
    req = 4'b0001;
    wait_done("abc", d, at);
    $display("abc: done=%b gnt=%b result=%h", d, gnt, result);
    chk("abc_done", 256'(d), 256'(4'b0001));
    chk("abc_gnt", 256'(gnt), 256'(4'b0001));
    chk("abc_result", result, ABC_HASH);
    chk("abc_cf_start_low", 256'(cf_start), 256'(0));
    req = '0;
    @(negedge clk);
    chk("abc_single_pulse", 256'(done), 256'(0));
    @(negedge clk);
    chk("abc_idle", 256'(busy), 256'(0));

    // Spurious cf_end in IDLE
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    $display("spurious cf_end: busy=%b result=%h", busy, result);
    chk("spur_busy", 256'(busy), 256'(0));
    chk("spur_gnt", 256'(gnt), 256'(0));
    chk("spur_result", result, ABC_HASH);

    // Round robin with all requesters held
    req_iv[255:0]  = {64{4'h1}};
    req_blk[511:0] = {{64{4'hA}}, {64{4'h0}}};
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    req  = 4'b1111;
    prev = 0;
    for (int n = 0; n < 5; n++) begin
      wait_done("rr", d, at);
      e = 4'b0001 << (n % 4);
      $display("rr op %0d: done=%b cycle=%0d result=%h", n, d, at, result);
      chk("rr_order", 256'(d), 256'(e));
      chk("rr_result", result, exp_hash(n % 4));
      chk("rr_cf_start_gap", 256'(cf_start), 256'(0));
      if (n > 0) chk("rr_spacing", 256'(at - prev), 256'(13));
      prev = at;
      if (n == 4) req = '0;
      @(negedge clk);
    end

    // Requester 2 drops its request mid-operation
    @(negedge clk);
    req = 4'b1100;
    wait_run();
    req = 4'b1000;
    @(negedge clk);
    chk("drop_gnt_held", 256'(gnt), 256'(4'b0100));
    wait_done("drop", d, at);
    $display("drop: done=%b result=%h", d, result);
    chk("drop_done2", 256'(d), 256'(4'b0100));
    chk("drop_result2", result, exp_hash(2));
    @(negedge clk);
    wait_done("drop_next", d, at);
    $display("drop next: done=%b result=%h", d, result);
    chk("drop_next_done3", 256'(d), 256'(4'b1000));
    chk("drop_next_result3", result, exp_hash(3));
    req = '0;
    @(negedge clk);

    // Reset during RUN abandons the operation
    @(negedge clk);
    req = 4'b0110;
    wait_run();
    saw = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done !== '0) saw = 1'b1;
    end
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 256'(busy), 256'(0));
    chk("rst_mid_gnt", 256'(gnt), 256'(0));
    chk("rst_mid_cf_start", 256'(cf_start), 256'(0));
    repeat (2) begin
      @(negedge clk);
      if (done !== '0) saw = 1'b1;
    end
    reset = 1'b1;
    @(negedge clk);
    $display("reset mid-run: done_seen=%b first gnt=%b", saw, gnt);
    chk("rst_mid_no_done", 256'(saw), 256'(0));
    chk("rst_mid_first_gnt", 256'(gnt), 256'(4'b0010));
    wait_done("rst_mid", d, at);
    chk("rst_mid_done1", 256'(d), 256'(4'b0010));
    chk("rst_mid_result1", result, exp_hash(1));
    req = '0;
    @(negedge clk);

    // Same requester re-granted, arbitration wrapping 3 -> 0 -> 3
    @(negedge clk);
    req = 4'b1000;
    wait_done("again_a", d, at);
    $display("repeat a: done=%b cycle=%0d", d, at);
    chk("again_a_done3", 256'(d), 256'(4'b1000));
    prev = at;
    @(negedge clk);
    wait_done("again_b", d, at);
    $display("repeat b: done=%b cycle=%0d", d, at);
    chk("again_b_done3", 256'(d), 256'(4'b1000));
    chk("again_spacing", 256'(at - prev), 256'(13));
    req = '0;
    @(negedge clk);

`ifdef SM3_ARB_LOCK_EN
    // One arbitrated grant to 1, then sixteen locked re-grants, then requester 0
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    lock = 4'b0010;
    req  = 4'b0011;
    for (int n = 0; n < 19; n++) begin
      wait_done("lock", d, at);
      e = (n == 0 || n == 18) ? 4'b0001 : 4'b0010;
      $display("lock op %0d: done=%b", n, d);
      chk("lock_order", 256'(d), 256'(e));
      @(negedge clk);
    end
    req  = '0;
    lock = '0;
    repeat (2) @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed run still active, required completion");
    $fatal(1, "simulation time limit exceeded");
  end

endmodule
